// File: rtl/alu_pkg.sv
// Shared opcode encodings and flag bit positions for the pipelined ALU.
package alu_pkg;

    localparam int OP_W      = 4;
    localparam int NUM_FLAGS = 4;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    // 0-6 match the legacy combinational ALU encoding
    localparam logic [OP_W-1:0] OP_ZERO  = 4'd0;
    localparam logic [OP_W-1:0] OP_ADD   = 4'd1;
    localparam logic [OP_W-1:0] OP_SUB   = 4'd2;
    localparam logic [OP_W-1:0] OP_AND   = 4'd3;
    localparam logic [OP_W-1:0] OP_OR    = 4'd4;
    localparam logic [OP_W-1:0] OP_NOTA  = 4'd5;
    localparam logic [OP_W-1:0] OP_NOTB  = 4'd6;
    localparam logic [OP_W-1:0] OP_XOR   = 4'd7;
    localparam logic [OP_W-1:0] OP_SHL   = 4'd8;
    localparam logic [OP_W-1:0] OP_SHR   = 4'd9;
    localparam logic [OP_W-1:0] OP_SRA   = 4'd10;
    localparam logic [OP_W-1:0] OP_PASSA = 4'd11;
    localparam logic [OP_W-1:0] OP_SLT   = 4'd12;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result and {V,C,N,Z} flags from registered operands.
// Optional ALU_SAT_EN clamps ADD/SUB to signed max/min on overflow.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [OP_W-1:0]      op,
    output logic [WIDTH-1:0]     result,
    output logic [NUM_FLAGS-1:0] flags
);

    localparam int SHW = $clog2(WIDTH);

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic [SHW-1:0]          shamt;
    logic [WIDTH:0]          sum;
    logic [WIDTH:0]          diff;
    logic                    add_v;
    logic                    sub_v;
    logic [WIDTH:0]          shl_ext;
    logic [WIDTH:0]          shr_ext;
    logic signed [WIDTH:0]   sra_ext;
    logic [WIDTH-1:0]        res;
    logic                    c;
    logic                    v;

`ifdef ALU_SAT_EN
    // On overflow the true result has the sign of A for both ADD and SUB
    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] wrapped,
                                                  input logic ovf,
                                                  input logic a_sign);
        if (!ovf)
            return wrapped;
        return a_sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction
`endif

    assign a_s   = a;
    assign b_s   = b;
    assign shamt = b[SHW-1:0];

    assign sum   = {1'b0, a} + {1'b0, b};
    assign diff  = {1'b0, a} - {1'b0, b};
    assign add_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
    assign sub_v = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

    // One guard bit past the result catches the last bit shifted out
    assign shl_ext = {1'b0, a} << shamt;
    assign shr_ext = {a, 1'b0} >> shamt;
    assign sra_ext = $signed({a, 1'b0}) >>> shamt;

    always_comb begin
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (op)
            OP_ZERO:  res = '0;
            OP_ADD: begin
                c = sum[WIDTH];
                v = add_v;
`ifdef ALU_SAT_EN
                res = saturate(sum[WIDTH-1:0], add_v, a[WIDTH-1]);
`else
                res = sum[WIDTH-1:0];
`endif
            end
            OP_SUB: begin
                c = diff[WIDTH];
                v = sub_v;
`ifdef ALU_SAT_EN
                res = saturate(diff[WIDTH-1:0], sub_v, a[WIDTH-1]);
`else
                res = diff[WIDTH-1:0];
`endif
            end
            OP_AND:   res = a & b;
            OP_OR:    res = a | b;
            OP_NOTA:  res = ~a;
            OP_NOTB:  res = ~b;
            OP_XOR:   res = a ^ b;
            OP_SHL: begin
                res = shl_ext[WIDTH-1:0];
                c   = shl_ext[WIDTH];
            end
            OP_SHR: begin
                res = shr_ext[WIDTH:1];
                c   = shr_ext[0];
            end
            OP_SRA: begin
                res = sra_ext[WIDTH:1];
                c   = sra_ext[0];
            end
            OP_PASSA: res = a;
            OP_SLT:   res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            default:  res = '0;
        endcase
    end

    always_comb begin
        result         = res;
        flags          = '0;
        flags[FLAG_V]  = v;
        flags[FLAG_C]  = c;
        flags[FLAG_N]  = res[WIDTH-1];
        flags[FLAG_Z]  = (res == '0);
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline: S1 holds operands, S2 holds result and flags.
// Build with ALU_SAT_EN defined for saturating ADD/SUB.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [OP_W-1:0]      Op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     alu_out,
    output logic [NUM_FLAGS-1:0] flags
);

    logic                 s1_valid;
    logic                 s2_valid;
    logic                 s1_adv;
    logic [WIDTH-1:0]     s1_a;
    logic [WIDTH-1:0]     s1_b;
    logic [OP_W-1:0]      s1_op;
    logic [WIDTH-1:0]     core_result;
    logic [NUM_FLAGS-1:0] core_flags;

    assign s1_adv    = ~s2_valid | out_ready;
    assign in_ready  = ~s1_valid | s1_adv;
    assign out_valid = s2_valid;

    // Stage 1: operand capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            s1_valid <= 1'b0;
        else if (in_ready)
            s1_valid <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (in_ready && in_valid) begin
            s1_a  <= A;
            s1_b  <= B;
            s1_op <= Op;
        end
    end

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a      (s1_a),
        .b      (s1_b),
        .op     (s1_op),
        .result (core_result),
        .flags  (core_flags)
    );

    // Stage 2: result register, held while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            alu_out  <= '0;
            flags    <= '0;
        end else if (s1_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                alu_out <= core_result;
                flags   <= core_flags;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe at WIDTH=4 with directed, hand-computed vectors.
module tb_alu_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] Op;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] alu_out;
    logic [3:0] flags;

    typedef struct packed {
        logic [3:0] res;
        logic [3:0] flg;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   beat_no = 0;
    logic [7:0] held;
    bit   held_v = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Op        (Op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_out   (alu_out),
        .flags     (flags)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pops on every output transfer and watches stalled beats for stability
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid) begin
            if (out_ready) begin
                held_v = 0;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%0h/%0h required=none", alu_out, flags);
                end else begin
                    e = q.pop_front();
                    check($sformatf("result_%0d", beat_no), {4'h0, alu_out}, {4'h0, e.res});
                    check($sformatf("flags_%0d", beat_no), {4'h0, flags}, {4'h0, e.flg});
                    beat_no++;
                end
            end else begin
                if (held_v)
                    check("hold_stable", {alu_out, flags}, held);
                held   = {alu_out, flags};
                held_v = 1;
            end
        end else begin
            held_v = 0;
        end
    end

    // Presents one beat (called at posedge+1) and queues its expected response at acceptance
    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                        input logic [3:0] r, input logic [3:0] f);
        int  n  = 0;
        bit  ok = 0;
        A = a; B = b; Op = op; in_valid = 1'b1;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (ok) begin
            q.push_back({r, f});
        end else begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout actual=0 required=1");
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", q.size(), 8'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; Op = '0; out_ready = 1'b1;
        #12;
        check("rst_out_valid", {7'd0, out_valid}, 8'd0);
        check("rst_in_ready",  {7'd0, in_ready},  8'd1);
        check("rst_alu_out",   {4'h0, alu_out},   8'd0);
        check("rst_flags",     {4'h0, flags},     8'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Legacy ops, A=3 B=1; flags are {V,C,N,Z}
        send(4'h3, 4'h1, 4'd0, 4'h0, 4'b0001);
        send(4'h3, 4'h1, 4'd1, 4'h4, 4'b0000);
        send(4'h3, 4'h1, 4'd2, 4'h2, 4'b0000);
        send(4'h3, 4'h1, 4'd3, 4'h1, 4'b0000);
        send(4'h3, 4'h1, 4'd4, 4'h3, 4'b0000);
        send(4'h3, 4'h1, 4'd5, 4'hC, 4'b0010);
        send(4'h3, 4'h1, 4'd6, 4'hE, 4'b0010);

        // Arithmetic flags and saturation
`ifdef ALU_SAT_EN
        send(4'h7, 4'h1, 4'd1, 4'h7, 4'b1000);
        send(4'h8, 4'h1, 4'd2, 4'h8, 4'b1010);
`else
        send(4'h7, 4'h1, 4'd1, 4'h8, 4'b1010);
        send(4'h8, 4'h1, 4'd2, 4'h7, 4'b1000);
`endif
        send(4'h1, 4'h3, 4'd2, 4'hE, 4'b0110);
        send(4'hF, 4'h1, 4'd1, 4'h0, 4'b0101);

        // Shifts
        send(4'b1001, 4'd1, 4'd8,  4'b0010, 4'b0100);
        send(4'b1000, 4'd2, 4'd10, 4'b1110, 4'b0010);
        send(4'b1011, 4'd0, 4'd9,  4'b1011, 4'b0010);
        send(4'b1000, 4'd3, 4'd9,  4'b0001, 4'b0000);
        send(4'b0001, 4'd3, 4'd8,  4'b1000, 4'b0010);
        send(4'b0111, 4'd1, 4'd10, 4'b0011, 4'b0100);

        // Remaining new ops and unused codes
        send(4'h5, 4'h3, 4'd7,  4'h6, 4'b0000);
        send(4'h9, 4'h0, 4'd11, 4'h9, 4'b0010);
        send(4'h8, 4'h1, 4'd12, 4'h1, 4'b0000);
        send(4'h1, 4'h8, 4'd12, 4'h0, 4'b0001);
        send(4'hA, 4'h5, 4'd13, 4'h0, 4'b0001);
        send(4'hF, 4'hF, 4'd15, 4'h0, 4'b0001);
        drain();

        // Back-pressure: consumer stalls for 3 cycles while 5 beats stream in
        out_ready = 1'b0;
        fork
            begin
                send(4'h1, 4'h1, 4'd1, 4'h2, 4'b0000);
                send(4'h2, 4'h1, 4'd1, 4'h3, 4'b0000);
                send(4'h6, 4'h3, 4'd7, 4'h5, 4'b0000);
                send(4'h4, 4'h1, 4'd2, 4'h3, 4'b0000);
                send(4'h6, 4'h1, 4'd8, 4'hC, 4'b0010);
            end
            begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                check("bp_in_ready_low", {7'd0, in_ready}, 8'd0);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two beats in flight
        out_ready = 1'b0;
        send(4'h2, 4'h3, 4'd1, 4'h5, 4'b0000);
        send(4'h7, 4'h2, 4'd2, 4'h5, 4'b0000);
        @(negedge clk);
        check("full_in_ready_low", {7'd0, in_ready}, 8'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_out_valid", {7'd0, out_valid}, 8'd0);
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        check("post_rst_in_ready", {7'd0, in_ready}, 8'd1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("no_stale_beat", {7'd0, out_valid}, 8'd0);
        @(posedge clk); #1;
        send(4'h2, 4'h2, 4'd1, 4'h4, 4'b0000);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
